// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared opcodes, phase encodings, error codes and control word
//            for the VeriRISC control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    typedef enum logic [2:0] {
        PH_ADDR    = 3'd0,
        PH_FETCH   = 3'd1,
        PH_LOAD    = 3'd2,
        PH_IDLE    = 3'd3,
        PH_OPADDR  = 3'd4,
        PH_OPFETCH = 3'd5,
        PH_ALU     = 3'd6,
        PH_STORE   = 3'd7
    } phase_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL = 2'd2;

    typedef enum logic {
        SRC_OPCODE  = 1'b0,
        SRC_TIMEOUT = 1'b1
    } halt_src_t;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic halt;
        logic ld_ac;
        logic wr;
        logic ld_pc;
        logic data_e;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational decode of phase/opcode/zero/halted into the
//            control word plus the opcode classes the sequencer needs.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  phase_t           i_phase,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_zero,
    input  logic             i_halted,
    output ctrl_t            o_ctrl,
    output logic             o_is_hlt,
    output logic             o_is_alu,
    output logic             o_is_sto,
    output logic             o_is_ill
);

    logic       w_ill;
    logic [2:0] w_op;
    logic       w_hlt;
    logic       w_skz;
    logic       w_alu;
    logic       w_sto;
    logic       w_jmp;

    assign w_op = i_opcode[2:0];

    // Any bit above the 3-bit opcode space marks the instruction illegal.
    generate
        if (OPC_W > 3) begin : g_wide_opc
            assign w_ill = |i_opcode[OPC_W-1:3];
        end else begin : g_narrow_opc
            assign w_ill = 1'b0;
        end
    endgenerate

    always_comb begin
        w_hlt = 1'b0;
        w_skz = 1'b0;
        w_alu = 1'b0;
        w_sto = 1'b0;
        w_jmp = 1'b0;
        if (!w_ill) begin
            case (w_op)
                HLT:                w_hlt = 1'b1;
                SKZ:                w_skz = 1'b1;
                ADD, AND, XOR, LDA: w_alu = 1'b1;
                STO:                w_sto = 1'b1;
                JMP:                w_jmp = 1'b1;
                default:            w_hlt = 1'b0;
            endcase
        end
    end

    always_comb begin
        o_ctrl = '0;
        if (i_halted) begin
            o_ctrl.halt = 1'b1;
        end else begin
            case (i_phase)
                PH_ADDR: o_ctrl.sel = 1'b1;
                PH_FETCH: begin
                    o_ctrl.sel = 1'b1;
                    o_ctrl.rd  = 1'b1;
                end
                PH_LOAD, PH_IDLE: begin
                    o_ctrl.sel   = 1'b1;
                    o_ctrl.rd    = 1'b1;
                    o_ctrl.ld_ir = 1'b1;
                end
                PH_OPADDR: begin
                    o_ctrl.inc_pc = 1'b1;
                    o_ctrl.halt   = w_hlt | w_ill;
                end
                PH_OPFETCH: o_ctrl.rd = w_alu;
                PH_ALU: begin
                    o_ctrl.rd     = w_alu;
                    o_ctrl.inc_pc = w_skz & i_zero;
                    o_ctrl.ld_pc  = w_jmp;
                    o_ctrl.data_e = w_sto;
                end
                PH_STORE: begin
                    o_ctrl.rd     = w_alu;
                    o_ctrl.ld_ac  = w_alu;
                    o_ctrl.wr     = w_sto;
                    o_ctrl.ld_pc  = w_jmp;
                    o_ctrl.data_e = w_sto;
                end
                default: o_ctrl = '0;
            endcase
        end
    end

    assign o_is_hlt = w_hlt;
    assign o_is_alu = w_alu;
    assign o_is_sto = w_sto;
    assign o_is_ill = w_ill;

endmodule
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Brief    : 8-phase VeriRISC sequencer with memory wait-state stalls,
//            sticky halt/resume and timeout / illegal-opcode reporting.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPC_W    = 3,
    parameter int TIMEOUT  = 15,
    parameter bit EN_STALL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             mem_rdy,
    input  logic             resume,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             halt,
    output logic             ld_ac,
    output logic             wr,
    output logic             ld_pc,
    output logic             data_e,
    output logic [2:0]       phase,
    output logic [1:0]       err,
    output logic             halted
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT);

    phase_t           r_phase;
    logic             r_halted;
    logic [1:0]       r_err;
    halt_src_t        r_halt_src;
    logic [CNT_W-1:0] r_stall_cnt;

    ctrl_t w_ctrl;
    ctrl_t w_out;
    logic  w_is_hlt;
    logic  w_is_alu;
    logic  w_is_sto;
    logic  w_is_ill;
    logic  w_mem_rdy;
    logic  w_stall_pt;
    logic  w_wait;
    logic  w_timeout;

    ctrl_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .i_phase  (r_phase),
        .i_opcode (opcode),
        .i_zero   (zero),
        .i_halted (r_halted),
        .o_ctrl   (w_ctrl),
        .o_is_hlt (w_is_hlt),
        .o_is_alu (w_is_alu),
        .o_is_sto (w_is_sto),
        .o_is_ill (w_is_ill)
    );

    // With stalls disabled the handshake is treated as permanently ready.
    assign w_mem_rdy  = mem_rdy | ~EN_STALL;
    assign w_stall_pt = (r_phase == PH_IDLE) ||
                        ((r_phase == PH_STORE) && (w_is_alu || w_is_sto));
    assign w_wait     = w_stall_pt && !w_mem_rdy;
    assign w_timeout  = w_wait && (r_stall_cnt == C_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= PH_ADDR;
            r_halted    <= 1'b0;
            r_err       <= ERR_NONE;
            r_halt_src  <= SRC_OPCODE;
            r_stall_cnt <= '0;
        end else if (r_halted) begin
            if (resume) begin
                r_halted    <= 1'b0;
                r_err       <= ERR_NONE;
                r_stall_cnt <= '0;
                // A timeout halt leaves the phase alone so the stall is retried.
                if (r_halt_src == SRC_OPCODE) begin
                    r_phase <= PH_OPFETCH;
                end
            end
        end else if (en) begin
            if ((r_phase == PH_OPADDR) && (w_is_hlt || w_is_ill)) begin
                r_halted   <= 1'b1;
                r_err      <= w_is_ill ? ERR_ILLEGAL : ERR_NONE;
                r_halt_src <= SRC_OPCODE;
            end else if (w_wait) begin
                if (w_timeout) begin
                    r_halted   <= 1'b1;
                    r_err      <= ERR_TIMEOUT;
                    r_halt_src <= SRC_TIMEOUT;
                end else begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end else begin
                r_phase     <= phase_t'(r_phase + 3'd1);
                r_stall_cnt <= '0;
            end
        end
    end

    assign w_out  = rst ? '0 : w_ctrl;
    assign sel    = w_out.sel;
    assign rd     = w_out.rd;
    assign ld_ir  = w_out.ld_ir;
    assign inc_pc = w_out.inc_pc;
    assign halt   = w_out.halt;
    assign ld_ac  = w_out.ld_ac;
    assign wr     = w_out.wr;
    assign ld_pc  = w_out.ld_pc;
    assign data_e = w_out.data_e;
    assign phase  = r_phase;
    assign err    = r_err;
    assign halted = r_halted;

endmodule
`default_nettype wire
